// File: rtl/jk_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_seq_if
// Description : Command channel between an upstream command source and
//               jk_cmd_seq. Valid/ready handshake carrying a {J,K} code and
//               a repeat count.
//   master : drives cmd_valid, cmd_jk, cmd_rpt; observes cmd_ready
//   slave  : observes cmd_valid, cmd_jk, cmd_rpt; drives cmd_ready
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_cmd_seq_if #(
   parameter int RPT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_jk;
   logic [RPT_W-1:0] cmd_rpt;

   modport master (output cmd_valid, output cmd_jk, output cmd_rpt, input  cmd_ready);
   modport slave  (input  cmd_valid, input  cmd_jk, input  cmd_rpt, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/jk_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : jk_cmd_seq
// Description : Queues {J,K} commands in a small FIFO and plays each one onto
//               registered j/k outputs for cmd_rpt+1 consecutive cycles,
//               back to back, while tracking the downstream JK flip-flop
//               state in q_shadow.
//   clk      in   single clock, rising edge
//   rst      in   asynchronous reset, active low
//   cmd      slv  command channel (cmd_valid/cmd_ready/cmd_jk/cmd_rpt)
//   j, k     out  registered drive to downstream flip-flop
//   q_shadow out  registered model of the downstream flip-flop output
//   busy     out  high while a command is being driven
//   done     out  one-cycle pulse after the last queued command completes
//   level    out  FIFO occupancy, 0..DEPTH
// Parameters  : DEPTH (power of two, >= 2), RPT_W (repeat field width)
// Revision    : 1.0 - initial release
// ============================================================================
module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int RPT_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   jk_cmd_seq_if.slave            cmd,
   output logic                   j,
   output logic                   k,
   output logic                   q_shadow,
   output logic                   busy,
   output logic                   done,
   output logic [$clog2(DEPTH):0] level
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_lvl_w = c_ptr_w + 1;
   localparam int c_ent_w = RPT_W + 2;
   localparam logic [c_lvl_w-1:0] c_full = c_lvl_w'(DEPTH);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   logic [c_ent_w-1:0] r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_lvl_w-1:0] r_level;
   logic [RPT_W-1:0]   r_cnt;
   state_t             r_state;

   logic               w_push;
   logic               w_slot_end;
   logic               w_pop;
   logic [c_ent_w-1:0] w_head;

   // Ready depends only on the registered level, so a pop while full frees
   // the slot for the following cycle, never the current one.
   assign cmd.cmd_ready = (r_level != c_full);
   assign w_push        = cmd.cmd_valid && cmd.cmd_ready;

   // A new command may be loaded whenever the output slot is free: either
   // nothing is running, or the running command is in its final cycle.
   assign w_slot_end = (r_state == S_IDLE) || (r_cnt == '0);
   assign w_pop      = w_slot_end && (r_level != '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign level      = r_level;

   // Storage needs no reset; only entries below r_level are ever read.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {cmd.cmd_jk, cmd.cmd_rpt};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_lvl_w'(1);
            2'b01:   r_level <= r_level - c_lvl_w'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         j        <= 1'b0;
         k        <= 1'b0;
         q_shadow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;

         // Downstream flip-flop samples the j/k we drove during this cycle.
         case ({j, k})
            2'b01:   q_shadow <= 1'b0;
            2'b10:   q_shadow <= 1'b1;
            2'b11:   q_shadow <= ~q_shadow;
            default: q_shadow <= q_shadow;
         endcase

         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  {j, k}  <= w_head[c_ent_w-1 -: 2];
                  r_cnt   <= w_head[RPT_W-1:0];
                  busy    <= 1'b1;
                  r_state <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - RPT_W'(1);
               end else if (w_pop) begin
                  {j, k} <= w_head[c_ent_w-1 -: 2];
                  r_cnt  <= w_head[RPT_W-1:0];
               end else begin
                  j       <= 1'b0;
                  k       <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               j       <= 1'b0;
               k       <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jk_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_cmd_seq
// Description : Directed self-checking bench for jk_cmd_seq (DEPTH=4,
//               RPT_W=4). Each check compares the packed observation
//               {j,k,q_shadow,busy,done,cmd_ready,level} with hand-computed
//               values, sampled 1 time unit after the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_cmd_seq;

   localparam int DEPTH = 4;
   localparam int RPT_W = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       j;
   logic       k;
   logic       q_shadow;
   logic       busy;
   logic       done;
   logic [2:0] level;

   int total = 0;
   int bad   = 0;

   jk_cmd_seq_if #(.RPT_W(RPT_W)) cif ();

   jk_cmd_seq #(
      .DEPTH(DEPTH),
      .RPT_W(RPT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd      (cif.slave),
      .j        (j),
      .k        (k),
      .q_shadow (q_shadow),
      .busy     (busy),
      .done     (done),
      .level    (level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [1:0] jk, input logic [3:0] rpt);
      cif.cmd_valid = 1'b1;
      cif.cmd_jk    = jk;
      cif.cmd_rpt   = rpt;
   endtask

   task automatic chk_st(input string tag, input logic ej, input logic ek,
                         input logic eq, input logic eb, input logic ed,
                         input logic er, input int elev);
      logic [8:0] obs;
      logic [8:0] exp;
      obs = {j, k, q_shadow, busy, done, cif.cmd_ready, level};
      exp = {ej, ek, eq, eb, ed, er, 3'(elev)};
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: {j,k,q,busy,done,ready,level} observed=%b expected=%b",
                tag, obs, exp);
      end
   endtask

   initial begin
      rst           = 1'b0;
      cif.cmd_valid = 1'b0;
      cif.cmd_jk    = 2'b00;
      cif.cmd_rpt   = '0;

      // ---------------- reset state
      tick();
      tick();
      chk_st("reset", 0, 0, 0, 0, 0, 1, 0);
      rst = 1'b1;

      // ---------------- single set command, rpt=2 (accepted on first edge)
      offer(2'b10, 4'd2);
      tick();
      cif.cmd_valid = 1'b0;
      chk_st("single_accept", 0, 0, 0, 0, 0, 1, 1);
      tick(); chk_st("single_c1",   1, 0, 0, 1, 0, 1, 0);
      tick(); chk_st("single_c2",   1, 0, 1, 1, 0, 1, 0);
      tick(); chk_st("single_c3",   1, 0, 1, 1, 0, 1, 0);
      tick(); chk_st("single_end",  0, 0, 1, 0, 1, 1, 0);
      tick(); chk_st("single_idle", 0, 0, 1, 0, 0, 1, 0);

      // ---------------- reset while idle clears q_shadow at once
      rst = 1'b0;
      #1;
      chk_st("rst_idle_async", 0, 0, 0, 0, 0, 1, 0);
      tick();
      rst = 1'b1;

      // ---------------- toggle, rpt=3
      offer(2'b11, 4'd3);
      tick();
      cif.cmd_valid = 1'b0;
      chk_st("tog_accept", 0, 0, 0, 0, 0, 1, 1);
      tick(); chk_st("tog_c1",   1, 1, 0, 1, 0, 1, 0);
      tick(); chk_st("tog_c2",   1, 1, 1, 1, 0, 1, 0);
      tick(); chk_st("tog_c3",   1, 1, 0, 1, 0, 1, 0);
      tick(); chk_st("tog_c4",   1, 1, 1, 1, 0, 1, 0);
      tick(); chk_st("tog_end",  0, 0, 0, 0, 1, 1, 0);
      tick(); chk_st("tog_hold", 0, 0, 0, 0, 0, 1, 0);

      // ---------------- back-to-back {10,0},{01,1},{11,0}
      offer(2'b10, 4'd0);
      tick(); chk_st("b2b_e0", 0, 0, 0, 0, 0, 1, 1);
      offer(2'b01, 4'd1);
      tick(); chk_st("b2b_e1", 1, 0, 0, 1, 0, 1, 1);
      offer(2'b11, 4'd0);
      tick();
      cif.cmd_valid = 1'b0;
      chk_st("b2b_e2", 0, 1, 1, 1, 0, 1, 1);
      tick(); chk_st("b2b_e3", 0, 1, 0, 1, 0, 1, 1);
      tick(); chk_st("b2b_e4", 1, 1, 0, 1, 0, 1, 0);
      tick(); chk_st("b2b_e5", 0, 0, 1, 0, 1, 1, 0);
      tick(); chk_st("b2b_e6", 0, 0, 1, 0, 0, 1, 0);

      // ---------------- full / backpressure
      rst = 1'b0;
      tick();
      rst = 1'b1;
      offer(2'b10, 4'd15);
      tick(); chk_st("full_e0", 0, 0, 0, 0, 0, 1, 1);
      offer(2'b01, 4'd0);
      for (int i = 1; i <= 16; i++) begin
         int  elev;
         elev = (i <= 3) ? i : 4;
         tick();
         chk_st($sformatf("full_e%0d", i), 1, 0, (i >= 2), 1, 0, (elev != 4), elev);
         if (i == 1)  offer(2'b10, 4'd0);
         if (i == 2)  offer(2'b11, 4'd1);
         if (i == 3)  offer(2'b01, 4'd0);
         if (i == 4)  offer(2'b10, 4'd2);   // offered while full, must be refused
         if (i == 10) cif.cmd_valid = 1'b0;
      end
      tick(); chk_st("full_e17", 0, 1, 1, 1, 0, 1, 3);
      tick(); chk_st("full_e18", 1, 0, 0, 1, 0, 1, 2);
      tick(); chk_st("full_e19", 1, 1, 1, 1, 0, 1, 1);
      tick(); chk_st("full_e20", 1, 1, 0, 1, 0, 1, 1);
      tick(); chk_st("full_e21", 0, 1, 1, 1, 0, 1, 0);
      tick(); chk_st("full_e22", 0, 0, 0, 0, 1, 1, 0);
      tick(); chk_st("full_no_extra", 0, 0, 0, 0, 0, 1, 0);

      // ---------------- reset mid-DRIVE with three queued
      offer(2'b10, 4'd7);
      tick();
      offer(2'b01, 4'd0);
      tick();
      offer(2'b11, 4'd0);
      tick();
      offer(2'b10, 4'd0);
      tick();
      cif.cmd_valid = 1'b0;
      chk_st("rmid_pre", 1, 0, 1, 1, 0, 1, 3);
      rst = 1'b0;
      #1;
      chk_st("rmid_async", 0, 0, 0, 0, 0, 1, 0);
      tick();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_st($sformatf("rmid_quiet%0d", i), 0, 0, 0, 0, 0, 1, 0);
      end

      // ---------------- fresh command after the aborted run
      offer(2'b01, 4'd0);
      tick();
      cif.cmd_valid = 1'b0;
      chk_st("post_accept", 0, 0, 0, 0, 0, 1, 1);
      tick(); chk_st("post_c1",  0, 1, 0, 1, 0, 1, 0);
      tick(); chk_st("post_end", 0, 0, 0, 0, 1, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
